block_luma_mean: RTL and testbench

//  Downstream consumer of the gamma-correction ROM: drives ROM address with incoming luma and accumulates

---
 rtl/block_luma_mean_pkg.sv | 32 +++
 rtl/block_luma_mean_if.sv | 34 +++
 rtl/block_luma_mean_sync_delay.sv | 24 ++
 rtl/block_luma_mean.sv | 133 +++++++++++++
 tb/tb_block_luma_mean.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/block_luma_mean_pkg.sv
// Shared sizing helpers and the zone result record for block_luma_mean.
// The zmax field exists only when BLOCK_MAX_EN is defined.
package blm_pkg;

    function automatic int acc_w(input int blk_w_log2, input int blk_h_log2);
        return 8 + blk_w_log2 + blk_h_log2;
    endfunction

    function automatic int zone_cols(input int img_w, input int blk_w_log2);
        return img_w >> blk_w_log2;
    endfunction

    function automatic int zone_rows(input int img_h, input int blk_h_log2);
        return img_h >> blk_h_log2;
    endfunction

    function automatic int shift_amt(input int blk_w_log2, input int blk_h_log2);
        return blk_w_log2 + blk_h_log2;
    endfunction

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic [7:0] col;
        logic [7:0] row;
        logic       done;
`ifdef BLOCK_MAX_EN
        logic [7:0] zmax;
`endif
    } zone_result_t;

endpackage

// File: rtl/block_luma_mean_if.sv
// Pixel-in / gamma-ROM / zone-result bundle. The mean_max member exists only
// when BLOCK_MAX_EN is defined. No handshake: pixels stream one per clock under
// pix_de, and mean_valid is a one-cycle strobe with no back-pressure.
interface block_luma_mean_if;
    logic       pix_vs;
    logic       pix_de;
    logic [7:0] pix_y;
    logic [7:0] gamma_addr;
    logic [7:0] gamma_data;
    logic       mean_valid;
    logic [7:0] mean_data;
    logic [7:0] mean_col;
    logic [7:0] mean_row;
    logic       frame_done;
`ifdef BLOCK_MAX_EN
    logic [7:0] mean_max;
`endif

    modport master (
        output pix_vs, pix_de, pix_y, gamma_data,
        input  gamma_addr, mean_valid, mean_data, mean_col, mean_row, frame_done
`ifdef BLOCK_MAX_EN
        , input mean_max
`endif
    );

    modport slave (
        input  pix_vs, pix_de, pix_y, gamma_data,
        output gamma_addr, mean_valid, mean_data, mean_col, mean_row, frame_done
`ifdef BLOCK_MAX_EN
        , output mean_max
`endif
    );
endinterface

// File: rtl/block_luma_mean_sync_delay.sv
// Delays {vs, de} by DEPTH clocks so the syncs line up with gamma ROM data.
module blm_sync_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic vs_i,
    input  logic de_i,
    output logic vs_o,
    output logic de_o
);
    logic [1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= {vs_i, de_i};
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign {vs_o, de_o} = pipe_q[DEPTH-1];
endmodule

// File: rtl/block_luma_mean.sv
// Per-zone mean of gamma-corrected luma, one result per BLK_W x BLK_H zone in raster order.
// Define BLOCK_MAX_EN to also report the per-zone maximum on mean_max.
module block_luma_mean
    import blm_pkg::*;
#(
    parameter int IMG_W      = 1024,
    parameter int IMG_H      = 768,
    parameter int BLK_W_LOG2 = 6,
    parameter int BLK_H_LOG2 = 6,
    parameter int ROM_LAT    = 2
) (
    input logic clk,
    input logic rst,
    block_luma_mean_if.slave bus
);
    localparam int ACC_W = acc_w(BLK_W_LOG2, BLK_H_LOG2);
    localparam int COLS  = zone_cols(IMG_W, BLK_W_LOG2);
    localparam int ROWS  = zone_rows(IMG_H, BLK_H_LOG2);
    localparam int SHIFT = shift_amt(BLK_W_LOG2, BLK_H_LOG2);
    localparam int XW    = $clog2(IMG_W + 1);
    localparam int YW    = $clog2(IMG_H + 1);
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

    logic             d_vs, d_de;
    logic             d_vs_q, d_de_q, active_q;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [ACC_W-1:0] acc_q [COLS];
    logic [ACC_W-1:0] acc_sum;
    logic [CW-1:0]    col_idx;
    logic             vs_rise, de_fall, pix_ok, zone_end, last_zone;
    zone_result_t     res_q, res_d;

    blm_sync_delay #(.DEPTH(ROM_LAT)) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .vs_i (bus.pix_vs),
        .de_i (bus.pix_de),
        .vs_o (d_vs),
        .de_o (d_de)
    );

    assign bus.gamma_addr = bus.pix_y;

    // A sync edge landing on an active pixel discards that pixel.
    assign vs_rise   = d_vs & ~d_vs_q;
    assign de_fall   = ~d_de & d_de_q;
    assign pix_ok    = active_q & d_de & ~vs_rise
                       & (x_q < XW'(IMG_W)) & (y_q < YW'(IMG_H));
    assign col_idx   = CW'(x_q >> BLK_W_LOG2);
    assign zone_end  = pix_ok & (&x_q[BLK_W_LOG2-1:0]) & (&y_q[BLK_H_LOG2-1:0]);
    assign last_zone = (int'(col_idx) == COLS - 1) && (int'(y_q >> BLK_H_LOG2) == ROWS - 1);
    assign acc_sum   = acc_q[col_idx] + ACC_W'(bus.gamma_data);

`ifdef BLOCK_MAX_EN
    logic [7:0] max_q [COLS];
    logic [7:0] max_new;
    assign max_new = (bus.gamma_data > max_q[col_idx]) ? bus.gamma_data : max_q[col_idx];
`endif

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (vs_rise) begin
            x_d = '0;
            y_d = '0;
        end else if (active_q) begin
            if (d_de) begin
                if (x_q < XW'(IMG_W)) x_d = x_q + 1'b1;
            end else if (de_fall) begin
                x_d = '0;
                if (y_q < YW'(IMG_H)) y_d = y_q + 1'b1;
            end
        end
    end

    always_comb begin
        res_d       = res_q;
        res_d.valid = 1'b0;
        res_d.done  = 1'b0;
        if (zone_end) begin
            res_d.valid = 1'b1;
            res_d.data  = 8'(acc_sum >> SHIFT);
            res_d.col   = 8'(col_idx);
            res_d.row   = 8'(y_q >> BLK_H_LOG2);
            res_d.done  = last_zone;
`ifdef BLOCK_MAX_EN
            res_d.zmax  = max_new;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_vs_q   <= 1'b0;
            d_de_q   <= 1'b0;
            active_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            res_q    <= '0;
            for (int c = 0; c < COLS; c++) acc_q[c] <= '0;
        end else begin
            d_vs_q <= d_vs;
            d_de_q <= d_de;
            x_q    <= x_d;
            y_q    <= y_d;
            res_q  <= res_d;
            if (vs_rise) active_q <= 1'b1;
            // The finishing pixel of a zone restarts its column accumulator at zero.
            for (int c = 0; c < COLS; c++) begin
                if (vs_rise) acc_q[c] <= '0;
                else if (pix_ok && col_idx == CW'(c)) acc_q[c] <= zone_end ? '0 : acc_sum;
            end
        end
    end

`ifdef BLOCK_MAX_EN
    always_ff @(posedge clk) begin
        for (int c = 0; c < COLS; c++) begin
            if (rst || vs_rise) max_q[c] <= '0;
            else if (pix_ok && col_idx == CW'(c)) max_q[c] <= zone_end ? 8'h00 : max_new;
        end
    end

    assign bus.mean_max = res_q.zmax;
`endif

    assign bus.mean_valid = res_q.valid;
    assign bus.mean_data  = res_q.data;
    assign bus.mean_col   = res_q.col;
    assign bus.mean_row   = res_q.row;
    assign bus.frame_done = res_q.done;
endmodule

// File: tb/tb_block_luma_mean.sv
// Bench for block_luma_mean on a reduced 256x12 image of 64x4 zones (4x3 zones).
// Build with BLOCK_MAX_EN defined to also check mean_max.
module tb_block_luma_mean;
    import blm_pkg::*;

    localparam int IMG_W   = 256;
    localparam int IMG_H   = 12;
    localparam int BW_LOG2 = 6;
    localparam int BH_LOG2 = 2;
    localparam int BLK_W   = 64;
    localparam int BLK_H   = 4;
    localparam int COLS    = 4;
    localparam int ROWS    = 3;
    localparam int H_BLANK = 4;
    localparam int NVEC    = 10;
`ifdef BLOCK_MAX_EN
    localparam int RW = 33;
`else
    localparam int RW = 25;
`endif

    localparam int K_FLAT = 0, K_FF = 1, K_ZONE = 2, K_RAMP = 3, K_RAND = 4, K_DOT = 5;
    localparam int ROM_ID = 0, ROM_GAMMA = 1;

    typedef struct {
        int kind;
        int rom_sel;
        int lines;
        int rst_line;
        int vs_de;
        int exp_n;
        int exp_first;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    block_luma_mean_if bus();

    block_luma_mean #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .BLK_W_LOG2(BW_LOG2), .BLK_H_LOG2(BH_LOG2), .ROM_LAT(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Gamma ROM: registered address, registered data -> two cycles of latency.
    logic [7:0] rom [256];
    logic [7:0] rom_addr_q;
    always @(posedge clk) begin
        rom_addr_q     <= bus.gamma_addr;
        bus.gamma_data <= rom[rom_addr_q];
    end

    logic [7:0]    img [IMG_H][IMG_W];
    logic [RW-1:0] exp_q[$];
    vec_t          vecs [NVEC];
    int            strobes, t_first, t_zone00;
    logic          first_seen;
    logic [7:0]    first_data;

    function automatic logic [RW:0] out_word();
`ifdef BLOCK_MAX_EN
        return {bus.mean_valid, bus.mean_data, bus.mean_col, bus.mean_row, bus.frame_done, bus.mean_max};
`else
        return {bus.mean_valid, bus.mean_data, bus.mean_col, bus.mean_row, bus.frame_done};
`endif
    endfunction

    // Scoreboard: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        logic [RW:0]   ow;
        logic [RW-1:0] got, want;
        ow = out_word();
        if (bus.frame_done && !bus.mean_valid) begin
            total++; bad++;
            $display("FAIL frame_done_alone got=1 want=0 at cyc %0d", cyc);
        end
        if (bus.mean_valid) begin
            strobes++;
            if (!first_seen) begin
                first_seen = 1'b1;
                t_first    = cyc;
                first_data = bus.mean_data;
            end
            total++;
            got = ow[RW-1:0];
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe got=%0h want=none at cyc %0d", got, cyc);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL zone_result got=%0h want=%0h at cyc %0d", got, want, cyc);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic load_rom(input int sel);
        for (int i = 0; i < 256; i++) begin
            if (sel == ROM_GAMMA) rom[i] = 8'($rtoi(255.0 * ((real'(i) / 255.0) ** (1.0 / 2.2)) + 0.5));
            else rom[i] = 8'(i);
        end
    endtask

    task automatic fill_img(input int kind);
        for (int y = 0; y < IMG_H; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                case (kind)
                    K_FLAT:  img[y][x] = 8'h80;
                    K_FF:    img[y][x] = 8'hFF;
                    K_ZONE:  img[y][x] = (x / BLK_W == 3 && y / BLK_H == 2) ? 8'hFF : 8'h00;
                    K_RAMP:  img[y][x] = 8'(x % 256);
                    K_RAND:  img[y][x] = 8'($urandom_range(0, 255));
                    default: img[y][x] = (x == 5 && y == 1) ? 8'hC0 : 8'h00;
                endcase
            end
        end
    endtask

    // Reference: plain average of ROM values over each zone whose lines all arrived.
    task automatic build_expect(input int lines_eff);
        int   sum;
        logic last;
`ifdef BLOCK_MAX_EN
        int   mx;
`endif
        exp_q.delete();
        for (int r = 0; r < lines_eff / BLK_H; r++) begin
            for (int c = 0; c < COLS; c++) begin
                sum = 0;
`ifdef BLOCK_MAX_EN
                mx = 0;
`endif
                for (int yy = r * BLK_H; yy < (r + 1) * BLK_H; yy++) begin
                    for (int xx = c * BLK_W; xx < (c + 1) * BLK_W; xx++) begin
                        sum += int'(rom[img[yy][xx]]);
`ifdef BLOCK_MAX_EN
                        if (int'(rom[img[yy][xx]]) > mx) mx = int'(rom[img[yy][xx]]);
`endif
                    end
                end
                last = (r == ROWS - 1) && (c == COLS - 1);
`ifdef BLOCK_MAX_EN
                exp_q.push_back({8'(sum / (BLK_W * BLK_H)), 8'(c), 8'(r), last, 8'(mx)});
`else
                exp_q.push_back({8'(sum / (BLK_W * BLK_H)), 8'(c), 8'(r), last});
`endif
            end
        end
    endtask

    task automatic drive_cycle(input logic vs, input logic de, input logic [7:0] y);
        @(negedge clk);
        bus.pix_vs = vs;
        bus.pix_de = de;
        bus.pix_y  = y;
    endtask

    task automatic run_frame(input int idx);
        vec_t v;
        v = vecs[idx];
        strobes    = 0;
        first_seen = 1'b0;
        t_zone00   = -1;
        fill_img(v.kind);
        load_rom(v.rom_sel);
        build_expect(v.rst_line >= 0 ? v.rst_line : v.lines);
        if (v.vs_de == 0) begin
            repeat (2) drive_cycle(1'b1, 1'b0, 8'h00);
            repeat (3) drive_cycle(1'b0, 1'b0, 8'h00);
        end
        for (int y = 0; y < v.lines; y++) begin
            if (y == v.rst_line) begin
                @(negedge clk);
                bus.pix_de = 1'b0;
                rst = 1'b1;
                repeat (4) @(negedge clk);
                check("midframe_reset_outputs", int'(out_word()), 0);
                rst = 1'b0;
            end
            // Junk pixel on the sync edge: must be dropped, line 0 starts right after.
            if (y == 0 && v.vs_de != 0) drive_cycle(1'b1, 1'b1, 8'h00);
            for (int x = 0; x < IMG_W; x++) begin
                drive_cycle(v.vs_de != 0 && y == 0, 1'b1, img[y][x]);
                if (x == BLK_W - 1 && y == BLK_H - 1) t_zone00 = cyc;
            end
            repeat (H_BLANK) drive_cycle(1'b0, 1'b0, 8'h00);
        end
        repeat (10) drive_cycle(1'b0, 1'b0, 8'h00);
        $display("vec%0d: strobes=%0d", idx, strobes);
        check("drain_left", exp_q.size(), 0);
        check("strobe_count", strobes, v.exp_n);
        if (v.exp_first >= 0) check("first_mean", int'(first_data), v.exp_first);
        if (v.exp_n > 0 && first_seen) check("latency", t_first - t_zone00, 3);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{K_FLAT, ROM_ID,    IMG_H, -1, 0, 12, 'h80};
        vecs[1] = '{K_FF,   ROM_GAMMA, IMG_H, -1, 0, 12, 'hFF};
        vecs[2] = '{K_ZONE, ROM_ID,    IMG_H, -1, 0, 12, 'h00};
        vecs[3] = '{K_RAMP, ROM_ID,    IMG_H, -1, 0, 12, 'h1F};
        vecs[4] = '{K_RAND, ROM_GAMMA, 10,    -1, 0, 8,  -1};
        vecs[5] = '{K_RAND, ROM_GAMMA, IMG_H, -1, 0, 12, -1};
        vecs[6] = '{K_FF,   ROM_ID,    IMG_H, -1, 1, 12, 'hFF};
        vecs[7] = '{K_RAND, ROM_ID,    IMG_H, 6,  0, 4,  -1};
        vecs[8] = '{K_FLAT, ROM_ID,    IMG_H, -1, 0, 12, 'h80};
        vecs[9] = '{K_DOT,  ROM_ID,    IMG_H, -1, 0, 12, 'h00};

        rst        = 1'b1;
        bus.pix_vs = 1'b0;
        bus.pix_de = 1'b0;
        bus.pix_y  = 8'h00;
        strobes    = 0;
        first_seen = 1'b0;
        load_rom(ROM_ID);
        repeat (5) @(negedge clk);
        check("reset_outputs", int'(out_word()), 0);
        bus.pix_y = 8'h5A;
        #1;
        check("gamma_addr_passthru", int'(bus.gamma_addr), 'h5A);
        rst = 1'b0;

        // Active pixels before any frame sync must be ignored.
        for (int y = 0; y < BLK_H; y++) begin
            for (int x = 0; x < IMG_W; x++) drive_cycle(1'b0, 1'b1, 8'hFF);
            repeat (H_BLANK) drive_cycle(1'b0, 1'b0, 8'h00);
        end
        repeat (10) drive_cycle(1'b0, 1'b0, 8'h00);
        check("no_vs_ignored", strobes, 0);

        for (int i = 0; i < NVEC; i++) run_frame(i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
